// File: rtl/turn_sequencer.sv
// Turn sequencer for a 2048-style board: accepts a player direction, drives the
// move/sum/move/spawn/check datapath operations in order and tracks win/loss/fault.
module turn_sequencer #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dir_valid,
    input  logic [3:0]  direction,
    output logic        dir_ready,
    output logic        op_start,
    output logic [2:0]  op_sel,
    output logic [3:0]  op_dir,
    input  logic        op_done,
    input  logic        board_changed,
    input  logic [4:0]  empty_cnt,
    input  logic        W,
    input  logic        L,
    output logic [3:0]  spawn_pos,
    output logic        spawn_four,
    output logic [1:0]  wl,
    output logic [15:0] turn_count
);

    // An all-zero seed would lock the LFSR up.
    localparam logic [15:0] SeedEff  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        StIdle, StMove1, StSum, StMove2, StSpawn, StCheck, StWon, StLost, StFault
    } state_e;

    state_e      state_q, state_d;
    logic        changed_q, changed_d;
    logic [15:0] wait_q, wait_d;
    logic [15:0] lfsr_q, lfsr_d;

    logic        dir_ready_d, op_start_d, spawn_four_d;
    logic [2:0]  op_sel_d;
    logic [3:0]  op_dir_d, spawn_pos_d;
    logic [1:0]  wl_d;
    logic [15:0] turn_count_d;
    logic        dir_onehot, changed_upd;

    function automatic logic [2:0] op_code(input state_e s);
        case (s)
            StMove1, StMove2: op_code = 3'b001;
            StSum:            op_code = 3'b010;
            StSpawn:          op_code = 3'b011;
            StCheck:          op_code = 3'b100;
            default:          op_code = 3'b000;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        changed_d    = changed_q;
        wait_d       = wait_q;
        op_dir_d     = op_dir;
        turn_count_d = turn_count;
        dir_onehot   = (direction != 4'd0) && ((direction & (direction - 4'd1)) == 4'd0);
        changed_upd  = changed_q | board_changed;

        if (state_q == StIdle) begin
            if (dir_valid && dir_ready && dir_onehot) begin
                op_dir_d  = direction;
                changed_d = 1'b0;
                state_d   = StMove1;
            end
        end else if (op_code(state_q) != 3'b000) begin
            // op_start marks the launch cycle; op_done only counts afterwards.
            if (op_start) begin
                wait_d = '0;
            end else if (op_done) begin
                case (state_q)
                    StMove1: begin
                        changed_d = changed_upd;
                        state_d   = StSum;
                    end
                    StSum: begin
                        changed_d = changed_upd;
                        state_d   = StMove2;
                    end
                    StMove2: begin
                        changed_d = changed_upd;
                        if (!changed_upd)             state_d = StIdle;
                        else if (empty_cnt != 5'd0)   state_d = StSpawn;
                        else                          state_d = StCheck;
                    end
                    StSpawn: state_d = StCheck;
                    StCheck: begin
                        if (turn_count != 16'hFFFF) turn_count_d = turn_count + 16'd1;
                        if (W)      state_d = StWon;
                        else if (L) state_d = StLost;
                        else        state_d = StIdle;
                    end
                    default: state_d = state_q;
                endcase
            end else if (wait_q == WaitLast) begin
                state_d = StFault;
            end else begin
                wait_d = wait_q + 16'd1;
            end
        end
    end

    // Outputs are registered copies of what the next state implies.
    always_comb begin
        dir_ready_d  = (state_d == StIdle);
        op_sel_d     = op_code(state_d);
        op_start_d   = (op_sel_d != 3'b000) && (state_d != state_q);
        spawn_pos_d  = spawn_pos;
        spawn_four_d = spawn_four;
        lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        case (state_d)
            StWon:   wl_d = 2'b10;
            StLost:  wl_d = 2'b01;
            StFault: wl_d = 2'b11;
            default: wl_d = 2'b00;
        endcase

        if (state_d == StSpawn && state_q != StSpawn) begin
            spawn_pos_d  = lfsr_q[3:0];
            spawn_four_d = (lfsr_q[7:5] == 3'b000);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            changed_q  <= 1'b0;
            wait_q     <= '0;
            lfsr_q     <= SeedEff;
            dir_ready  <= 1'b1;
            op_start   <= 1'b0;
            op_sel     <= 3'b000;
            op_dir     <= 4'b0000;
            spawn_pos  <= 4'd0;
            spawn_four <= 1'b0;
            wl         <= 2'b00;
            turn_count <= 16'd0;
        end else begin
            state_q    <= state_d;
            changed_q  <= changed_d;
            wait_q     <= wait_d;
            lfsr_q     <= lfsr_d;
            dir_ready  <= dir_ready_d;
            op_start   <= op_start_d;
            op_sel     <= op_sel_d;
            op_dir     <= op_dir_d;
            spawn_pos  <= spawn_pos_d;
            spawn_four <= spawn_four_d;
            wl         <= wl_d;
            turn_count <= turn_count_d;
        end
    end

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: directed vector table, randomized turns
// against a turn-level model, plus timeout and mid-turn reset sequences.
module tb_turn_sequencer;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst, dir_valid, op_done, board_changed, W, L;
    logic [3:0]  direction;
    logic [4:0]  empty_cnt;
    logic        dir_ready, op_start, spawn_four;
    logic [2:0]  op_sel;
    logic [3:0]  op_dir, spawn_pos;
    logic [1:0]  wl;
    logic [15:0] turn_count;

    int checks   = 0;
    int failures = 0;
    logic [15:0] lfsr_m, lfsr_prev;
    int exp_tc;

    always #5 clk = ~clk;

    turn_sequencer #(.LFSR_SEED(SEED), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .dir_valid(dir_valid), .direction(direction),
        .dir_ready(dir_ready), .op_start(op_start), .op_sel(op_sel), .op_dir(op_dir),
        .op_done(op_done), .board_changed(board_changed), .empty_cnt(empty_cnt),
        .W(W), .L(L), .spawn_pos(spawn_pos), .spawn_four(spawn_four), .wl(wl),
        .turn_count(turn_count)
    );

    typedef struct {
        logic [3:0] dir;
        logic [2:0] chg;
        logic [4:0] empty;
        logic       w;
        logic       l;
        int         dly;
        logic       spur;
        int         exp_seq;
        int         exp_tc;
        logic [1:0] exp_wl;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], ^(x & 16'hB400)};
    endfunction

    // Expected op_sel sequence of one turn, one octal digit per op_start.
    function automatic int model_seq(input logic [3:0] dir, input logic [2:0] chg,
                                     input logic [4:0] empty);
        if ($countones(dir) != 1) return 0;
        if (chg == 3'b000) return 'o121;
        return (empty != 0) ? 'o12134 : 'o1214;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        lfsr_prev = lfsr_m;
        lfsr_m    = rst ? SEED : lfsr_next(lfsr_m);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; dir_valid = 1'b0; op_done = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic check_reset(input string name);
        check(name, {dir_ready, op_start, op_sel, op_dir, spawn_pos, spawn_four, wl}, 16'h8000);
        check({name, "_tc"}, turn_count, 0);
    endtask

    task automatic terminal_hold(input logic [1:0] exp_wl);
        for (int i = 0; i < 5; i++) begin
            dir_valid = 1'b1; direction = 4'b0001; op_done = 1'b1;
            cycle();
            check("terminal", {dir_ready, op_start, wl}, {1'b0, 1'b0, exp_wl});
        end
        dir_valid = 1'b0; op_done = 1'b0;
    endtask

    // Plays one turn as the datapath; stops in IDLE, a terminal state, or on abort_op.
    task automatic run_turn(input logic [3:0] dir, input logic [2:0] chg, input logic [4:0] empty,
                            input logic w, input logic l, input int dly, input logic spur,
                            input int abort_op, output int seq, output bit hold_ok);
        int cnt   = 0;
        int nmove = 0;
        int cur   = 0;
        bit done  = 0;
        seq = 0; hold_ok = 1;
        empty_cnt = empty;
        dir_valid = 1'b1; direction = dir;
        cycle();
        dir_valid = 1'b0; direction = 4'b0000;
        for (int i = 0; i < 400 && !done; i++) begin
            op_done = 1'b0; board_changed = 1'($urandom_range(0, 1));
            W = 1'($urandom_range(0, 1)); L = 1'($urandom_range(0, 1));
            if (op_start) begin
                if (seq == 0) check("op_dir", op_dir, dir);
                seq = (seq << 3) | int'(op_sel);
                cur = int'(op_sel);
                cnt = dly;
                if (op_sel == 3'b011) begin
                    check("spawn_pos", spawn_pos, lfsr_prev[3:0]);
                    check("spawn_four", spawn_four, lfsr_prev[7:5] == 3'b000);
                end
                if (cur == abort_op) done = 1;
                else if (spur) begin op_done = 1'b1; board_changed = 1'b1; W = 1'b1; L = 1'b1; end
            end else if (dir_ready || wl != 2'b00) begin
                done = 1;
            end else begin
                if (int'(op_sel) != cur) hold_ok = 0;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        op_done = 1'b1;
                        if (cur == 1 || cur == 2) begin
                            board_changed = chg[nmove];
                            nmove++;
                        end
                        if (cur == 4) begin W = w; L = l; end
                    end
                end
            end
            if (!done) cycle();
        end
        op_done = 1'b0;
        if (!done) check("turn_budget", 0, 1);
    endtask

    initial begin
        int  seq;
        bit  hold;
        int  e_seq;
        logic [1:0] e_wl;
        logic [3:0] rdir;
        logic [2:0] rchg;
        logic [4:0] remp;
        logic rw, rl;

        rst = 1'b1; dir_valid = 1'b0; direction = 4'b0000; op_done = 1'b0;
        board_changed = 1'b0; W = 1'b0; L = 1'b0; empty_cnt = 5'd0;

        //            dir     chg     empty w     l     dly spur  seq      tc  wl
        vecs[0] = '{4'b0010, 3'b001, 5'd5, 1'b0, 1'b0, 3,  1'b0, 'o12134, 1, 2'b00};
        vecs[1] = '{4'b0001, 3'b000, 5'd7, 1'b0, 1'b0, 2,  1'b0, 'o121,   1, 2'b00};
        vecs[2] = '{4'b1000, 3'b010, 5'd0, 1'b0, 1'b0, 5,  1'b1, 'o1214,  2, 2'b00};
        vecs[3] = '{4'b0110, 3'b111, 5'd4, 1'b0, 1'b0, 1,  1'b0, 0,       2, 2'b00};
        vecs[4] = '{4'b0000, 3'b111, 5'd4, 1'b0, 1'b0, 1,  1'b0, 0,       2, 2'b00};
        vecs[5] = '{4'b0100, 3'b100, 5'd3, 1'b0, 1'b0, 16, 1'b0, 'o12134, 3, 2'b00};
        vecs[6] = '{4'b0010, 3'b001, 5'd4, 1'b1, 1'b1, 1,  1'b1, 'o12134, 4, 2'b10};
        vecs[7] = '{4'b0001, 3'b001, 5'd0, 1'b0, 1'b1, 4,  1'b0, 'o1214,  1, 2'b01};

        do_reset();
        check_reset("reset_initial");
        for (int i = 0; i < 8; i++) begin
            run_turn(vecs[i].dir, vecs[i].chg, vecs[i].empty, vecs[i].w, vecs[i].l,
                     vecs[i].dly, vecs[i].spur, -1, seq, hold);
            check("vec_seq", seq, vecs[i].exp_seq);
            check("vec_tc", turn_count, vecs[i].exp_tc);
            check("vec_wl", wl, vecs[i].exp_wl);
            check("vec_hold", hold, 1);
            if (vecs[i].exp_wl != 2'b00) begin
                terminal_hold(vecs[i].exp_wl);
                do_reset();
                check_reset("reset_after_end");
            end else begin
                check("vec_idle", dir_ready, 1);
            end
        end

        // Randomized turns against the turn-level model.
        do_reset();
        exp_tc = 0;
        for (int i = 0; i < 40; i++) begin
            rdir = ($urandom_range(0, 7) < 6) ? 4'(4'b0001 << $urandom_range(0, 3))
                                              : 4'($urandom_range(0, 15));
            rchg = 3'($urandom_range(0, 7));
            remp = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 16));
            rw   = ($urandom_range(0, 11) == 0);
            rl   = ($urandom_range(0, 11) == 0);
            run_turn(rdir, rchg, remp, rw, rl, $urandom_range(1, 16),
                     1'($urandom_range(0, 1)), -1, seq, hold);
            e_seq = model_seq(rdir, rchg, remp);
            e_wl  = 2'b00;
            if (e_seq % 8 == 4) begin
                if (exp_tc < 65535) exp_tc++;
                e_wl = rw ? 2'b10 : (rl ? 2'b01 : 2'b00);
            end
            check("rnd_seq", seq, e_seq);
            check("rnd_tc", turn_count, exp_tc);
            check("rnd_wl", wl, e_wl);
            check("rnd_hold", hold, 1);
            if (e_wl != 2'b00) begin
                terminal_hold(e_wl);
                do_reset();
                exp_tc = 0;
            end
        end

        // Timeout: SUM's op_done withheld.
        do_reset();
        dir_valid = 1'b1; direction = 4'b0001;
        cycle();
        dir_valid = 1'b0;
        check("to_move1_start", {op_start, op_sel}, 4'b1001);
        cycle();
        cycle();
        op_done = 1'b1; board_changed = 1'b1;
        cycle();
        op_done = 1'b0;
        check("to_sum_start", {op_start, op_sel}, 4'b1010);
        repeat (16) cycle();
        check("to_last_wait", {wl, op_sel}, 5'b00010);
        cycle();
        check("to_fault", wl, 2'b11);
        terminal_hold(2'b11);
        do_reset();
        check_reset("reset_after_fault");

        // Reset mid-SPAWN with a concurrent op_done, then the LFSR restarts.
        run_turn(4'b0010, 3'b001, 5'd9, 1'b0, 1'b0, 2, 1'b0, 3, seq, hold);
        check("mid_seq", seq, 'o1213);
        op_done = 1'b1; board_changed = 1'b1;
        rst = 1'b1;
        cycle();
        rst = 1'b0; op_done = 1'b0;
        check_reset("reset_mid_spawn");
        run_turn(4'b0010, 3'b001, 5'd9, 1'b0, 1'b0, 2, 1'b0, -1, seq, hold);
        check("post_reset_seq", seq, 'o12134);
        check("post_reset_tc", turn_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
